// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default parameters for the instruction-fetch stage
package fetch_pkg;
  localparam int DEF_XLEN = 64;
  localparam int DEF_ILEN = 32;
  localparam int DEF_FQ_DEPTH = 4;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = '0;
  typedef enum logic {RUN, HALT} fetch_state_e;
  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] instr;
    logic misalign;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO; flush discards the contents, and an enq in the
// same cycle lands as the sole entry of the emptied queue.
module fetch_queue import fetch_pkg::*; #(
  parameter int DEPTH = DEF_FQ_DEPTH,
  parameter type T = fq_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic enq,
  input  T enq_data,
  input  logic deq,
  output T head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count <= '0;
    end else if (flush) begin
      rd_q <= '0;
      wr_q <= AW'(enq);
      count <= CW'(enq);
    end else begin
      rd_q <= rd_q + AW'(deq);
      wr_q <= wr_q + AW'(enq);
      count <= count + CW'(enq) - CW'(deq);
    end
  end
  always_ff @(posedge clk)
    if (enq) mem[flush ? '0 : wr_q] <= enq_data;
  assign head = mem[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, redirect handling and credit-based issue into a
// decoupling fetch queue feeding ID.
module fetch_unit import fetch_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int ILEN = DEF_ILEN,
  parameter int FQ_DEPTH = DEF_FQ_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic clk,
  input  logic rst,
  output logic o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [ILEN-1:0] i_imem_rdata,
  input  logic i_ex_redirect,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic i_id_redirect,
  input  logic [XLEN-1:0] i_id_target,
  output logic o_valid,
  input  logic i_id_ready,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic o_misalign,
  output logic [$clog2(FQ_DEPTH):0] o_fq_count
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic misalign;
  } entry_t;
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, tgt;
  logic inflight_q, redirect, aligned, deq, credit, issue, enq;
  logic [CW:0] occ;
  logic [CW-1:0] count;
  entry_t enq_data, head;
  assign redirect = ~rst & (i_ex_redirect | i_id_redirect);
  assign tgt = i_ex_redirect ? i_ex_target : i_id_target;
  assign aligned = tgt[1:0] == 2'b00;
  assign o_valid = ~rst & ~redirect & (count != '0);
  assign deq = o_valid & i_id_ready;
  // Entries the queue will hold once the outstanding response lands, net of this cycle's dequeue.
  assign occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(deq);
  assign credit = occ < (CW+1)'(FQ_DEPTH);
  assign issue = redirect ? aligned : (~rst & (state_q == RUN) & credit);
  assign o_imem_req = issue;
  assign o_imem_addr = redirect ? {tgt[XLEN-1:2], 2'b00} : pc_q;
  assign enq = redirect ? ~aligned : (~rst & inflight_q);
  assign enq_data = redirect ? entry_t'{pc: tgt, instr: '0, misalign: 1'b1}
                             : entry_t'{pc: req_pc_q, instr: i_imem_rdata, misalign: 1'b0};
  assign o_instr = o_valid ? head.instr : '0;
  assign o_pc = o_valid ? head.pc : '0;
  assign o_misalign = o_valid & head.misalign;
  assign o_fq_count = rst ? '0 : count;
  always_comb begin
    state_d = redirect ? (aligned ? RUN : HALT) : state_q;
    pc_d = issue ? o_imem_addr + XLEN'(4) : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      req_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inflight_q <= issue;
      if (issue) req_pc_q <= o_imem_addr;
    end
  end
  fetch_queue #(.DEPTH(FQ_DEPTH), .T(entry_t)) u_fq (
    .clk(clk),
    .rst(rst),
    .flush(redirect),
    .enq(enq),
    .enq_data(enq_data),
    .deq(deq),
    .head(head),
    .count(count)
  );
endmodule
